muldiv_hilo_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from ID/EX, iterates one bit per cycle, and writes HI/LO.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Drives a stall that holds the pipeline registers whenever an instruction needs HI/LO, or needs the unit, while an operation is in flight.

---
 rtl/muldiv_hilo_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO
// registers of the EX stage. Operands are reduced to magnitudes on accept,
// iterated one bit per cycle (shift-add / restoring shift-subtract), then
// sign-corrected and written to HI/LO. Also serves MFHI/MFLO and MTHI/MTLO and
// raises a stall while the unit is busy.
module muldiv_hilo_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            hl_rd_i,
    input  logic            hl_wr_i,
    input  logic            hl_sel_i,
    input  logic [XLEN-1:0] hl_wdata_i,
    output logic [XLEN-1:0] hl_rdata_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic            dz_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          op_q;        // op_q[1]: divide, op_q[0]: unsigned
    logic [XLEN-1:0]     mag_a_q;
    logic [XLEN-1:0]     mag_b_q;
    logic                neg_res_q;   // result (product / quotient) negative
    logic                neg_rem_q;   // dividend negative -> remainder negative
    logic [2*XLEN-1:0]   acc_q;       // product, or {remainder, quotient/dividend}
    logic [XLEN-1:0]     hi_q;
    logic [XLEN-1:0]     lo_q;
    logic                busy_q;
    logic                done_q;
    logic                dz_q;

    logic                neg_a_d;
    logic                neg_b_d;
    logic [XLEN-1:0]     mag_a_d;
    logic [XLEN-1:0]     mag_b_d;
    logic [XLEN:0]       mul_sum_d;
    logic [2*XLEN-1:0]   mul_next_d;
    logic [XLEN:0]       rem_sh_d;
    logic [XLEN+1:0]     trial_d;
    logic                q_bit_d;
    logic [XLEN-1:0]     rem_next_d;
    logic [2*XLEN-1:0]   div_next_d;
    logic [2*XLEN-1:0]   prod_fix_d;
    logic [XLEN-1:0]     quo_fix_d;
    logic [XLEN-1:0]     rem_fix_d;

    // Operand magnitudes and signs for the op being presented (signed ops only).
    always_comb begin
        neg_a_d = ~op_i[0] & a_i[XLEN-1];
        neg_b_d = ~op_i[0] & b_i[XLEN-1];
        mag_a_d = neg_a_d ? (~a_i + {{(XLEN-1){1'b0}}, 1'b1}) : a_i;
        mag_b_d = neg_b_d ? (~b_i + {{(XLEN-1){1'b0}}, 1'b1}) : b_i;
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix.
    always_comb begin
        mul_sum_d  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                   + (acc_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
        mul_next_d = {mul_sum_d, acc_q[XLEN-1:1]};

        rem_sh_d   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        trial_d    = {1'b0, rem_sh_d} - {2'b00, mag_b_q};
        q_bit_d    = ~trial_d[XLEN+1];
        rem_next_d = q_bit_d ? trial_d[XLEN-1:0] : rem_sh_d[XLEN-1:0];
        div_next_d = {rem_next_d, acc_q[XLEN-2:0], q_bit_d};

        prod_fix_d = neg_res_q ? (~acc_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_q;
        quo_fix_d  = neg_res_q ? (~acc_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                               : acc_q[XLEN-1:0];
        rem_fix_d  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                               : acc_q[2*XLEN-1:XLEN];
    end

    // Sequencer FSM with datapath, HI/LO ownership and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            op_q      <= 2'b00;
            mag_a_q   <= {XLEN{1'b0}};
            mag_b_q   <= {XLEN{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= {(2*XLEN){1'b0}};
            hi_q      <= {XLEN{1'b0}};
            lo_q      <= {XLEN{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // MTHI/MTLO lands now; a same-cycle op overwrites at completion.
                    if (hl_wr_i) begin
                        if (hl_sel_i) hi_q <= hl_wdata_i;
                        else          lo_q <= hl_wdata_i;
                    end
                    if (start_i) begin
                        op_q      <= op_i;
                        mag_a_q   <= mag_a_d;
                        mag_b_q   <= mag_b_d;
                        neg_res_q <= neg_a_d ^ neg_b_d;
                        neg_rem_q <= neg_a_d;
                        busy_q    <= 1'b1;
                        state_q   <= ST_PREP;
                    end else begin
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (op_q[1] && (mag_b_q == {XLEN{1'b0}})) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        dz_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        acc_q   <= op_q[1] ? {{XLEN{1'b0}}, mag_a_q}
                                           : {{XLEN{1'b0}}, mag_b_q};
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_q <= op_q[1] ? div_next_d : mul_next_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_LAST) state_q <= ST_FIX;
                    else                   state_q <= ST_CALC;
                end
                ST_FIX: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix_d;
                        lo_q <= quo_fix_d;
                    end else begin
                        hi_q <= prod_fix_d[2*XLEN-1:XLEN];
                        lo_q <= prod_fix_d[XLEN-1:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hl_rdata_o = hl_sel_i ? hi_q : lo_q;
    assign stall_o    = busy_q & (start_i | hl_rd_i | hl_wr_i);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign dz_o       = dz_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: a vector table plus random ops
// checked through an expectation queue, and hand sequences for divide-by-zero,
// stall/read-during-busy, write-with-start and mid-operation reset.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i, b_i;
    logic        hl_rd_i, hl_wr_i, hl_sel_i;
    logic [31:0] hl_wdata_i;
    logic [31:0] hl_rdata_o, hi_o, lo_o;
    logic        busy_o, stall_o, done_o, dz_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi, m_lo;   // bench's view of HI/LO

    muldiv_hilo_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .hl_rd_i(hl_rd_i), .hl_wr_i(hl_wr_i), .hl_sel_i(hl_sel_i), .hl_wdata_i(hl_wdata_i),
        .hl_rdata_o(hl_rdata_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o),
        .stall_o(stall_o), .done_o(done_o), .dz_o(dz_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: returns {hi, lo}; divide by zero leaves HI/LO alone.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0: begin p = sa * sb; return p; end
            2'd1: begin p = ua * ub; return p; end
            2'd2: begin
                if (b == 32'd0) return prev;
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return prev;
                uq = ua / ub; ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Push the expected completion for an op and update the HI/LO model.
    task automatic expect_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        r = model(op, a, b, {m_hi, m_lo});
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.dz  = op[1] && (b == 32'd0);
        e.lat = e.dz ? 2 : 35;
        m_hi  = e.hi;
        m_lo  = e.lo;
        sb_q.push_back(e);
    endtask

    // Called at the first falling edge after the accept edge; waits for done_o.
    task automatic collect(input string name);
        int   n;
        int   bc;
        exp_t e;
        n  = 1;
        bc = 0;
        while (!done_o && n < 100) begin
            bc += busy_o;
            @(negedge clk);
            n++;
        end
        if (sb_q.size() == 0) begin
            chk({name, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_done"}, {63'd0, done_o}, 64'd1);
            chk({name, "_latency"}, n, e.lat);
            chk({name, "_busy_cycles"}, bc, e.lat - 1);
            chk({name, "_dz"}, {63'd0, dz_o}, {63'd0, e.dz});
            chk({name, "_hi"}, hi_o, e.hi);
            chk({name, "_lo"}, lo_o, e.lo);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        expect_op(op, a, b);
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        collect(name);
        @(negedge clk);
        chk({name, "_done_once"}, {63'd0, done_o}, 64'd0);
        chk({name, "_idle"}, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic mt(input logic sel, input logic [31:0] d);
        @(negedge clk);
        hl_wr_i = 1'b1; hl_sel_i = sel; hl_wdata_i = d;
        @(negedge clk);
        hl_wr_i = 1'b0;
        if (sel) m_hi = d; else m_lo = d;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[5] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[6] = '{2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8] = '{2'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};

        rst = 1'b1; start_i = 1'b0; op_i = 2'd0; a_i = 32'd0; b_i = 32'd0;
        hl_rd_i = 1'b0; hl_wr_i = 1'b0; hl_sel_i = 1'b0; hl_wdata_i = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_hi", hi_o, 64'd0);
        chk("reset_lo", lo_o, 64'd0);
        chk("reset_busy", {63'd0, busy_o}, 64'd0);
        chk("reset_done", {63'd0, done_o}, 64'd0);
        chk("reset_dz", {63'd0, dz_o}, 64'd0);

        // Table vectors: constant expectations, also cross-checked via scoreboard.
        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_tbl", i), {hi_o, lo_o}, {vecs[i].hi, vecs[i].lo});
        end

        // Random ops checked against the reference model.
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom | 32'd1;
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // MTHI/MTLO preload then DIVU by zero: HI/LO must survive.
        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        hl_sel_i = 1'b1;
        #1 chk("mthi_read", hl_rdata_o, 64'h11);
        hl_sel_i = 1'b0;
        #1 chk("mtlo_read", hl_rdata_o, 64'h22);
        run_op("divu_by_zero", 2'd3, 32'd9, 32'd0);
        chk("dz_keep", {hi_o, lo_o}, {32'h11, 32'h22});

        // MFHI held during DIVU 100/7, plus a second start raised during CALC.
        expect_op(2'd3, 32'd100, 32'd7);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        hl_rd_i = 1'b1; hl_sel_i = 1'b1;
        #1 chk("mfhi_stall", {63'd0, stall_o}, 64'd1);
        chk("mfhi_old_value", hl_rdata_o, 64'h11);
        repeat (5) @(negedge clk);
        hl_rd_i = 1'b0;
        start_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd4;
        #1 chk("start_busy_stall", {63'd0, stall_o}, 64'd1);
        hl_rd_i = 1'b1;
        @(negedge clk);
        chk("start_ignored_busy", {63'd0, busy_o}, 64'd1);
        // Back up to the accept-relative count of collect: 9 falling edges so far.
        begin
            int   n;
            exp_t e;
            n = 9;
            while (!done_o && n < 100) begin
                if (!stall_o) chk("stall_held", {63'd0, stall_o}, 64'd1);
                @(negedge clk);
                n++;
            end
            e = sb_q.pop_front();
            chk("mfhi_latency", n, e.lat);
            chk("mfhi_done_stall", {63'd0, stall_o}, 64'd0);
            chk("mfhi_done_rdata", hl_rdata_o, {32'd0, e.hi});
            chk("mfhi_lo", lo_o, {32'd0, e.lo});
        end
        expect_op(2'd1, 32'd3, 32'd4);
        @(negedge clk);
        start_i = 1'b0; hl_rd_i = 1'b0;
        collect("second_start");

        // MTLO and start in the same idle cycle: write lands, result overwrites.
        @(negedge clk);
        hl_wr_i = 1'b1; hl_sel_i = 1'b0; hl_wdata_i = 32'hABCD;
        start_i = 1'b1; op_i = 2'd1; a_i = 32'd5; b_i = 32'd6;
        m_lo = 32'hABCD;
        expect_op(2'd1, 32'd5, 32'd6);
        @(negedge clk);
        hl_wr_i = 1'b0; start_i = 1'b0;
        chk("wr_with_start_lo", lo_o, 64'hABCD);
        collect("wr_with_start");

        // Reset at counter = 10 of a MULT.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd0; a_i = 32'hFFFF1234; b_i = 32'd77;
        @(negedge clk);
        start_i = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_hi", hi_o, 64'd0);
        chk("midrst_lo", lo_o, 64'd0);
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                seen += done_o;
                @(negedge clk);
            end
            chk("midrst_no_done", seen, 0);
        end
        run_op("after_reset", 2'd1, 32'd6, 32'd7);
        chk("after_reset_val", {hi_o, lo_o}, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
